// File: rtl/kmac_pkg.sv
// Shared constants and the state encoding for the KMAC message padder.
package kmac_pkg;

    localparam logic [7:0] DsSha3  = 8'h06;
    localparam logic [7:0] DsShake = 8'h1F;
    localparam logic [7:0] PadEnd  = 8'h80;

    typedef enum logic [2:0] {
        StMsg     = 3'd0,
        StPadDs   = 3'd1,
        StPadZero = 3'd2,
        StRun     = 3'd3,
        StDone    = 3'd4
    } padder_st_e;

endpackage

// File: rtl/kmac_pad_byte_ins.sv
// Masks unstrobed bytes, drops the DS byte into the first unstrobed lane and
// ORs the block-end marker into byte 7 when the word closes the rate block.
module kmac_pad_byte_ins
    import kmac_pkg::*;
(
    input  logic [63:0] data_i,
    input  logic [7:0]  strb_i,
    input  logic [7:0]  ds_i,
    input  logic        last_i,
    output logic [63:0] data_o
);

    logic ins_done;

    always_comb begin
        data_o   = '0;
        ins_done = 1'b0;
        // Strobe is LSB-contiguous, so the first clear lane follows the message bytes.
        for (int b = 0; b < 8; b++) begin
            if (strb_i[b]) begin
                data_o[8*b +: 8] = data_i[8*b +: 8];
            end else if (!ins_done) begin
                data_o[8*b +: 8] = ds_i;
                ins_done         = 1'b1;
            end
        end
        if (last_i) begin
            data_o[63:56] = data_o[63:56] | PadEnd;
        end
    end

endmodule

// File: rtl/kmac_msg_padder.sv
// Forwards message words into the Keccak absorb port and appends SHA3/SHAKE padding.
// Define KMAC_PADDER_SHAKE_EN to let shake_i select the SHAKE domain byte.
module kmac_msg_padder
    import kmac_pkg::*;
#(
    parameter int OutWidth    = 64,
    parameter int BlockWords  = 17,
    parameter int BlockWordsW = $clog2(BlockWords)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   msg_valid_i,
    input  logic [OutWidth-1:0]    msg_data_i,
    input  logic [OutWidth/8-1:0]  msg_strb_i,
    output logic                   msg_ready_o,
    input  logic                   process_i,
    input  logic                   shake_i,
    output logic                   keccak_valid_o,
    output logic [BlockWordsW-1:0] keccak_addr_o,
    output logic [OutWidth-1:0]    keccak_data_o,
    input  logic                   keccak_ready_i,
    output logic                   keccak_run_o,
    input  logic                   keccak_done_i,
    output logic                   absorbed_o,
    input  logic                   clear_i
);

    localparam logic [BlockWordsW-1:0] LastAddr = BlockWordsW'(BlockWords - 1);

    padder_st_e             st_q, st_d;
    logic [BlockWordsW-1:0] addr_q, addr_d;
    logic                   pad_started_q, pad_started_d;
    logic                   final_q, final_d;
    logic                   pend_q, pend_d;
    logic                   run_q, run_d;
    logic                   absorbed_q, absorbed_d;

    logic [7:0]          ds;
    logic                in_msg, pad_st, at_last, msg_partial;
    logic                accept_en, xfer, proc_req;
    logic [OutWidth-1:0] ins_data, padded;
    logic [7:0]          ins_strb;
    logic                ins_last;

`ifdef KMAC_PADDER_SHAKE_EN
    assign ds = shake_i ? DsShake : DsSha3;
`else
    logic unused_shake;
    assign unused_shake = shake_i;
    assign ds           = DsSha3;
`endif

    assign in_msg      = (st_q == StMsg);
    assign pad_st      = (st_q == StPadDs) || (st_q == StPadZero);
    assign at_last     = (addr_q == LastAddr);
    assign msg_partial = (msg_strb_i != 8'hFF);

    // After a partial word or with a latched process request, no more message words are taken.
    assign accept_en      = in_msg && !pad_started_q && !pend_q;
    assign msg_ready_o    = accept_en && keccak_ready_i;
    assign keccak_valid_o = (accept_en && msg_valid_i) || pad_st;
    assign xfer           = keccak_valid_o && keccak_ready_i;
    assign proc_req       = process_i || pend_q;

    assign ins_data = in_msg ? msg_data_i : '0;
    assign ins_strb = in_msg ? msg_strb_i : ((st_q == StPadDs) ? 8'h00 : 8'hFF);
    assign ins_last = at_last && (pad_st || (in_msg && msg_partial));

    kmac_pad_byte_ins u_pad_byte_ins (
        .data_i (ins_data),
        .strb_i (ins_strb),
        .ds_i   (ds),
        .last_i (ins_last),
        .data_o (padded)
    );

    assign keccak_data_o = keccak_valid_o ? padded : '0;
    assign keccak_addr_o = addr_q;
    assign keccak_run_o  = run_q;
    assign absorbed_o    = absorbed_q;

    always_comb begin
        st_d          = st_q;
        addr_d        = addr_q;
        pad_started_d = pad_started_q;
        final_d       = final_q;
        pend_d        = pend_q;
        run_d         = 1'b0;
        absorbed_d    = 1'b0;

        if (process_i && ((st_q == StRun) || (in_msg && xfer))) begin
            pend_d = 1'b1;
        end

        case (st_q)
            StMsg: begin
                if (xfer) begin
                    addr_d = at_last ? '0 : addr_q + 1'b1;
                    if (msg_partial) begin
                        pad_started_d = 1'b1;
                        if (at_last) final_d = 1'b1;
                    end
                    if (at_last) begin
                        st_d  = StRun;
                        run_d = 1'b1;
                    end
                end else if (proc_req) begin
                    st_d   = pad_started_q ? StPadZero : StPadDs;
                    pend_d = 1'b0;
                end
            end
            StPadDs, StPadZero: begin
                if (keccak_ready_i) begin
                    if (at_last) begin
                        addr_d  = '0;
                        final_d = 1'b1;
                        st_d    = StRun;
                        run_d   = 1'b1;
                    end else begin
                        addr_d = addr_q + 1'b1;
                        st_d   = StPadZero;
                    end
                end
            end
            StRun: begin
                if (keccak_done_i) begin
                    if (final_q) begin
                        st_d       = StDone;
                        absorbed_d = 1'b1;
                    end else begin
                        st_d          = StMsg;
                        pad_started_d = 1'b0;
                    end
                end
            end
            StDone: begin
                st_d = StDone;
            end
            default: begin
                st_d = StMsg;
            end
        endcase

        if (clear_i) begin
            st_d          = StMsg;
            addr_d        = '0;
            pad_started_d = 1'b0;
            final_d       = 1'b0;
            pend_d        = 1'b0;
            run_d         = 1'b0;
            absorbed_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q          <= StMsg;
            addr_q        <= '0;
            pad_started_q <= 1'b0;
            final_q       <= 1'b0;
            pend_q        <= 1'b0;
            run_q         <= 1'b0;
            absorbed_q    <= 1'b0;
        end else begin
            st_q          <= st_d;
            addr_q        <= addr_d;
            pad_started_q <= pad_started_d;
            final_q       <= final_d;
            pend_q        <= pend_d;
            run_q         <= run_d;
            absorbed_q    <= absorbed_d;
        end
    end

endmodule
